tanh_pack: RTL and testbench
============================

Name: tanh_pack

Overview:
- Downstream consumer of the tanh pipeline. Takes the signed Q2.12 f(x) stream over a valid/ready handshake.
- Each sample is rounded and saturated to signed 8-bit Q0.7. LANES samples are packed into one output word.
- Finished words are buffered in a small output FIFO so the tanh pipeline is not stalled by short downstream back-pressure.
- i_last closes a partial word early; the valid bytes are marked with a keep mask.

Parameters:
- LANES, 4, number of 8-bit samples per output word; power of two, 2..8.
- DEPTH, 4, output FIFO depth in words; power of two, >=2.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- i_fx  in  14  signed Q2.12 sample from tanh.
- i_valid  in  1  i_fx/i_last valid.
- i_last  in  1  sample ends a frame; flush the partial word.
- o_ready  out  1  block accepts a sample this cycle.
- o_data  out  8*LANES  packed word; sample k occupies bits [8k+7:8k].
- o_keep  out  LANES  byte-valid mask; contiguous from bit 0.
- o_last  out  1  word ends a frame.
- o_valid  out  1  o_data/o_keep/o_last valid.
- i_ready  in  1  downstream accepts the word.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, lane counter 0, pack register 0.
  - o_valid=0, o_data=0, o_keep=0, o_last=0.
  - o_ready=1 after reset release.
  - Reset mid-frame discards any partial word and all buffered words.
- Input handshake:
  - Accept when i_valid && o_ready.
  - o_ready = (fifo_count < DEPTH); it is a registered-count function only, with no combinational path from i_ready.
- Conversion, combinational, per accepted sample:
  - s = (i_fx + 16) >>> 5, computed at 15 bits signed (round half up).
  - If s > 127 the byte is 0x7F. If s < -128 the byte is 0x80. Otherwise the byte is s[7:0].
- Packing:
  - Lane counter lc runs 0..LANES-1. The accepted byte is written to lane lc of the pack register.
  - Word completes when lc==LANES-1 or i_last=1.
  - On completion, push {pack with current byte, keep=(1<<(lc+1))-1, last=i_last} to the FIFO and reset lc to 0.
  - On a non-completing accept, lc increments.
  - Unused lanes of a partial word are 0.
- FIFO and output:
  - FIFO head drives o_data/o_keep/o_last/o_valid; o_valid = !empty.
  - Pop on o_valid && i_ready.
  - Push and pop in the same cycle: count unchanged, ordering preserved.
- Full: o_ready=0. A word completing at the cycle count reaches DEPTH is accepted because the check uses the pre-push count. No sample is ever dropped.
- Empty: o_valid=0, and o_data holds the last popped value.
- Latency: the sample completing a word is accepted at cycle t; the word is on o_data with o_valid=1 at t+1 if the FIFO was empty.
- Throughput: one sample per cycle sustained while i_ready=1.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- i_last with lc==LANES-1 gives a full word with o_keep all ones and o_last=1.
- Inputs are ignored when i_valid=0. While o_ready=0, i_fx and i_last must be held by the source.

Test Plan:
- Conversion:
  - Stimulus (LANES=4): i_fx = 2048, 16, 15, -16, no i_last.
  - Required: one word, o_data=0x00000140, o_keep=0xF, o_last=0, o_valid one cycle after the 4th accept.
- Saturation:
  - Stimulus: i_fx = 4096, -4096, 8191, -8192.
  - Required: bytes 0x7F, 0x80, 0x7F, 0x80, so o_data=0x807F807F.
- Partial flush:
  - Stimulus: i_fx = 1024, 512 with i_last on the 2nd sample.
  - Required: o_data=0x00001020, o_keep=0x3, o_last=1. The next word starts at lane 0.
- Back-pressure:
  - Stimulus: i_ready=0 and stream 4*DEPTH+3 samples.
  - Required: o_ready falls after DEPTH words are buffered. Release i_ready and all DEPTH+1 words (3-byte last) arrive in order with no loss or duplication.
- Streaming:
  - Stimulus: i_ready=1, 64 back-to-back samples with ramp i_fx = 32*k.
  - Required: 16 words, one every 4 cycles, each byte = k mod 256 as signed; o_ready never drops.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously with 2 words buffered and lc=2.
  - Required: o_valid=0 immediately. After release, the first word contains only post-reset samples.

Source files
------------

// File: rtl/tanh_pack.sv
// tanh_pack: rounds and saturates the signed Q2.12 tanh stream to signed
// Q0.7 bytes, packs LANES bytes per output word and buffers finished words
// in a small FIFO so the tanh pipeline rides through short downstream stalls.
//
// Ports:
//   clk       clock, all state on posedge
//   rst_n     asynchronous active-low reset
//   i_fx      signed Q2.12 sample
//   i_valid   i_fx / i_last valid
//   i_last    sample ends a frame, closes the partial word
//   o_ready   block accepts a sample this cycle (FIFO not full)
//   o_data    packed word, sample k in bits [8k+7:8k]
//   o_keep    byte-valid mask, contiguous from bit 0
//   o_last    word ends a frame
//   o_valid   o_data / o_keep / o_last valid (FIFO not empty)
//   i_ready   downstream accepts the word
module tanh_pack #(
   parameter int LANES = 4,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [13:0]          i_fx,
   input  logic                 i_valid,
   input  logic                 i_last,
   output logic                 o_ready,
   output logic [8*LANES-1:0]   o_data,
   output logic [LANES-1:0]     o_keep,
   output logic                 o_last,
   output logic                 o_valid,
   input  logic                 i_ready
);

   localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   // FIFO entry layout: {last, keep, data}
   localparam int WW  = 8*LANES + LANES + 1;

   // ------------------------------------------------------------------
   // Conversion: round half up, then saturate to Q0.7
   // ------------------------------------------------------------------
   logic signed [14:0] w_sum;
   logic signed [14:0] w_s;
   logic [7:0]         w_byte;

   always_comb begin
      w_sum = $signed({i_fx[13], i_fx}) + 15'sd16;
      w_s   = w_sum >>> 5;
      if (w_s > 15'sd127)
         w_byte = 8'h7F;
      else if (w_s < -15'sd128)
         w_byte = 8'h80;
      else
         w_byte = w_s[7:0];
   end

   // ------------------------------------------------------------------
   // Packing
   // ------------------------------------------------------------------
   logic [LCW-1:0]     r_lc;
   logic [8*LANES-1:0] r_pack;
   logic [8*LANES-1:0] w_word_data;
   logic [LANES-1:0]   w_word_keep;
   logic [WW-1:0]      w_word;
   logic               w_accept;
   logic               w_complete;
   logic               w_lane_end;

   logic [CW-1:0]      r_count;
   logic [PW-1:0]      r_wr_ptr;
   logic [PW-1:0]      r_rd_ptr;
   logic [WW-1:0]      r_mem [DEPTH];
   logic [WW-1:0]      r_hold;
   logic [WW-1:0]      w_head;
   logic [WW-1:0]      w_out;
   logic               w_pop;

   // Ready depends only on the registered count, never on i_ready.
   assign o_ready    = (r_count < CW'(DEPTH));
   assign o_valid    = (r_count != '0);
   assign w_accept   = i_valid && o_ready;
   assign w_lane_end = (r_lc == LCW'(LANES-1));
   assign w_complete = w_accept && (w_lane_end || i_last);
   assign w_pop      = o_valid && i_ready;

   // The completing word is the pack register with the current byte merged
   // into lane lc. Lanes above lc are still zero because the pack register
   // is cleared on every completion.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign w_word_data[8*gi +: 8] = (r_lc == LCW'(gi)) ? w_byte : r_pack[8*gi +: 8];
         assign w_word_keep[gi]        = (LCW'(gi) <= r_lc);
      end
   endgenerate

   assign w_word = {i_last, w_word_keep, w_word_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lc   <= '0;
         r_pack <= '0;
      end else if (w_accept) begin
         if (w_complete) begin
            r_lc   <= '0;
            r_pack <= '0;
         end else begin
            r_lc                <= r_lc + LCW'(1);
            r_pack[8*r_lc +: 8] <= w_byte;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------
   // A push can never hit a full FIFO: completion requires an accept, and
   // an accept requires count < DEPTH before the push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (w_complete) begin
         r_mem[r_wr_ptr] <= w_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_complete)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_complete && !w_pop)
            r_count <= r_count + CW'(1);
         else if (!w_complete && w_pop)
            r_count <= r_count - CW'(1);
      end
   end

   // r_hold keeps the last popped word so the outputs stay put while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_hold <= '0;
      else if (w_pop)
         r_hold <= w_head;
   end

   assign w_head = r_mem[r_rd_ptr];
   assign w_out  = o_valid ? w_head : r_hold;
   assign o_data = w_out[8*LANES-1:0];
   assign o_keep = w_out[8*LANES +: LANES];
   assign o_last = w_out[WW-1];

endmodule

// File: tb/tb_tanh_pack.sv
module tb_tanh_pack;

   localparam int LANES = 4;
   localparam int DEPTH = 4;
   localparam int W     = 8*LANES + LANES + 1;

   logic               clk;
   logic               rst_n;
   logic [13:0]        i_fx;
   logic               i_valid;
   logic               i_last;
   logic               o_ready;
   logic [8*LANES-1:0] o_data;
   logic [LANES-1:0]   o_keep;
   logic               o_last;
   logic               o_valid;
   logic               i_ready;

   tanh_pack #(.LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_fx    (i_fx),
      .i_valid (i_valid),
      .i_last  (i_last),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_keep  (o_keep),
      .o_last  (o_last),
      .o_valid (o_valid),
      .i_ready (i_ready)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int stall_cnt = 0;
   int n_acc  = 0;
   bit rnd_rdy = 0;
   bit bp_done = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];
   int           obs_cyc[$];
   logic [7:0]   m_bytes[$];

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Word leaves the DUT at the next posedge; inputs only change at posedge+1.
   always @(negedge clk) begin
      if (rst_n && o_valid && i_ready) begin
         obs_q.push_back({o_last, o_keep, o_data});
         obs_cyc.push_back(cyc);
         $display("word data=%h keep=%b last=%0d cyc=%0d", o_data, o_keep, o_last, cyc);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_rdy) i_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Reference: round to nearest (half up) of fx/32, then clamp to int8.
   function automatic logic [7:0] model_byte(input int fx);
      int s;
      s = $rtoi($floor(real'(fx) / 32.0 + 0.5));
      if (s > 127)  return 8'h7F;
      if (s < -128) return 8'h80;
      return s[7:0];
   endfunction

   function automatic void model_accept(input int fx, input bit last);
      logic [8*LANES-1:0] d;
      logic [LANES-1:0]   k;
      m_bytes.push_back(model_byte(fx));
      if (m_bytes.size() == LANES || last) begin
         d = '0;
         k = '0;
         foreach (m_bytes[i]) begin
            d[8*i +: 8] = m_bytes[i];
            k[i] = 1'b1;
         end
         exp_q.push_back({last, k, d});
         m_bytes.delete();
      end
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input int fx, input bit last);
      int waitc = 0;
      i_fx    = 14'(fx);
      i_last  = last;
      i_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (o_ready) break;
         stall_cnt++;
         waitc++;
         if (waitc > 300) begin
            checks++; errors++;
            $display("FAIL send_timeout fx=%0d ready stayed 0", fx);
            i_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_last  = 1'b0;
      n_acc++;
      model_accept(fx, last);
   endtask

   task automatic wait_drain();
      int t = 0;
      while (obs_q.size() < exp_q.size() && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic clear_queues();
      exp_q.delete();
      obs_q.delete();
      obs_cyc.delete();
   endtask

   task automatic test_reset();
      rst_n = 0; i_fx = '0; i_valid = 0; i_last = 0; i_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      @(posedge clk);
      #1;
      checks++;
      if ({o_valid, o_data, o_keep, o_last} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b d=%h k=%b l=%b want all 0", o_valid, o_data, o_keep, o_last);
      end
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", o_ready);
      end
   endtask

   task automatic test_conversion();
      send(2048, 0); send(16, 0); send(15, 0);
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL conv_early_valid got %b want 0", o_valid);
      end
      send(-16, 0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 32'h0000_0140 || o_keep !== 4'hF || o_last !== 1'b0) begin
         errors++;
         $display("FAIL conv_word got v=%b d=%h k=%h l=%b want v=1 d=00000140 k=f l=0", o_valid, o_data, o_keep, o_last);
      end
      wait_drain();
   endtask

   task automatic test_saturation();
      send(4096, 0); send(-4096, 0); send(8191, 0); send(-8192, 0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 32'h807F_807F) begin
         errors++;
         $display("FAIL sat_word got v=%b d=%h want v=1 d=807f807f", o_valid, o_data);
      end
      wait_drain();
   endtask

   task automatic test_partial();
      send(1024, 0); send(512, 1);
      checks++;
      if (o_data !== 32'h0000_1020 || o_keep !== 4'h3 || o_last !== 1'b1) begin
         errors++;
         $display("FAIL partial_word got d=%h k=%h l=%b want d=00001020 k=3 l=1", o_data, o_keep, o_last);
      end
      send(2048, 1);
      checks++;
      if (o_data !== 32'h0000_0040 || o_keep !== 4'h1 || o_last !== 1'b1) begin
         errors++;
         $display("FAIL partial_next_lane0 got d=%h k=%h l=%b want d=00000040 k=1 l=1", o_data, o_keep, o_last);
      end
      wait_drain();
   endtask

   task automatic check_scoreboard(input string name);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s_count got %0d words want %0d", name, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s_word%0d got %h want %h", name, i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int t;
      i_ready = 0;
      n_acc   = 0;
      bp_done = 0;
      fork
         begin
            for (int k = 0; k < 4*DEPTH + 3; k++)
               send($urandom_range(0, 16383) - 8192, k == 4*DEPTH + 2);
            bp_done = 1;
         end
      join_none
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || n_acc != 4*DEPTH || obs_q.size() != 0) begin
         errors++;
         $display("FAIL bp_full got ready=%b valid=%b acc=%0d obs=%0d want 0 1 %0d 0", o_ready, o_valid, n_acc, obs_q.size(), 4*DEPTH);
      end
      i_ready = 1;
      t = 0;
      while (!bp_done && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      checks++;
      if (!bp_done) begin
         errors++;
         $display("FAIL bp_sender_done got 0 want 1");
      end
      wait_drain();
      checks++;
      if (obs_q.size() != DEPTH + 1 || obs_q[obs_q.size()-1][W-1 -: LANES+1] !== {1'b1, 4'b0111}) begin
         errors++;
         $display("FAIL bp_last_word got n=%0d want n=%0d with keep=7 last=1", obs_q.size(), DEPTH + 1);
      end
      checks++;
      if (o_valid !== 1'b0 || o_data !== exp_q[exp_q.size()-1][8*LANES-1:0]) begin
         errors++;
         $display("FAIL bp_hold got v=%b d=%h want v=0 d=%h", o_valid, o_data, exp_q[exp_q.size()-1][8*LANES-1:0]);
      end
      check_scoreboard("bp");
      clear_queues();
   endtask

   task automatic test_streaming();
      i_ready   = 1;
      stall_cnt = 0;
      for (int k = 0; k < 64; k++) send(32*k, 0);
      wait_drain();
      checks++;
      if (stall_cnt != 0) begin
         errors++;
         $display("FAIL stream_ready_drop got %0d stalls want 0", stall_cnt);
      end
      for (int i = 1; i < obs_cyc.size(); i++) begin
         checks++;
         if (obs_cyc[i] - obs_cyc[i-1] != 4) begin
            errors++;
            $display("FAIL stream_spacing%0d got %0d cycles want 4", i, obs_cyc[i] - obs_cyc[i-1]);
         end
      end
      check_scoreboard("stream");
      clear_queues();
   endtask

   task automatic test_random();
      int fx;
      int edges [6] = '{4079, 4080, -4112, -4113, 8191, -8192};
      rnd_rdy = 1;
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 4) == 0) fx = edges[$urandom_range(0, 5)];
         else fx = $urandom_range(0, 16383) - 8192;
         send(fx, $urandom_range(0, 5) == 0);
      end
      send(100, 1);
      rnd_rdy = 0;
      @(posedge clk);
      #1;
      i_ready = 1;
      wait_drain();
      check_scoreboard("random");
      clear_queues();
   endtask

   task automatic test_reset_mid();
      i_ready = 0;
      for (int k = 0; k < 2*LANES + 2; k++) send($urandom_range(0, 16383) - 8192, 0);
      #2;
      rst_n = 0;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== '0) begin
         errors++;
         $display("FAIL rstmid_async got v=%b r=%b d=%h want v=0 r=1 d=0", o_valid, o_ready, o_data);
      end
      clear_queues();
      m_bytes.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1;
      i_ready = 1;
      send(2048, 0); send(1024, 0); send(512, 0); send(32, 0);
      wait_drain();
      checks++;
      if (obs_q.size() < 1 || obs_q[0] !== {1'b0, 4'hF, 32'h0110_2040}) begin
         errors++;
         $display("FAIL rstmid_first_word got n=%0d w=%h want 0f01102040", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0);
      end
      check_scoreboard("rstmid");
      clear_queues();
   endtask

   initial begin
      test_reset();
      test_conversion();
      check_scoreboard("conv");
      clear_queues();
      test_saturation();
      check_scoreboard("sat");
      clear_queues();
      test_partial();
      check_scoreboard("partial");
      clear_queues();
      test_back_to_back();
      test_streaming();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
